// File: rtl/trainer_pkg.sv
// Shared types and defaults for hebbian_trainer: FSM states, default widths,
// iteration-counter width and the default-width saturation limits.
package trainer_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int OUT_W_DEF  = 32;
  localparam int ITER_W     = 8;

  localparam logic signed [DATA_W_DEF-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [DATA_W_DEF-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_EVAL,
    ST_LEARN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/trainer_err_sat.sv
// Combinational error path: target minus neuron output in OUT_W+1 bits,
// arithmetic right shift by ERR_SHIFT, then saturation to signed DATA_W.
module trainer_err_sat
  import trainer_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int OUT_W     = OUT_W_DEF,
  parameter int ERR_SHIFT = 4
) (
  input  logic signed [OUT_W-1:0]  i_target,
  input  logic signed [OUT_W-1:0]  i_actual,
  output logic signed [DATA_W-1:0] o_err
);

  localparam logic signed [DATA_W-1:0] LIM_HI = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] LIM_LO = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [OUT_W:0] w_diff;
  logic signed [OUT_W:0] w_shift;
  logic                  w_fits;

  // The shifted value fits DATA_W when every bit above the DATA_W sign bit matches it.
  always_comb begin
    w_diff  = {i_target[OUT_W-1], i_target} - {i_actual[OUT_W-1], i_actual};
    w_shift = w_diff >>> ERR_SHIFT;
    w_fits  = (w_shift[OUT_W:DATA_W-1] == {(OUT_W-DATA_W+2){w_shift[OUT_W]}});
    if (w_fits) begin
      o_err = w_shift[DATA_W-1:0];
    end else if (w_shift[OUT_W]) begin
      o_err = LIM_LO;
    end else begin
      o_err = LIM_HI;
    end
  end

endmodule

// File: rtl/hebbian_trainer.sv
// Closed-loop supervisor for one plastic neuron. Define TRAINER_CONVERGE_EN to
// repeat LEARN/WAIT/EVAL until convergence or MAX_ITER; otherwise at most one LEARN.
module hebbian_trainer
  import trainer_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int NEURON_LAT = 1,
  parameter int ERR_SHIFT  = 4,
  parameter int ERR_TOL    = 0,
  parameter int MAX_ITER   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_stim,
  input  logic [OUT_W-1:0]  s_target,
  input  logic              s_train,
  output logic [DATA_W-1:0] neuron_in,
  input  logic [OUT_W-1:0]  neuron_out,
  output logic [DATA_W-1:0] feedback_error,
  output logic              learn_en,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [DATA_W-1:0] r_error,
  output logic [ITER_W-1:0] r_iters,
  output logic              r_converged
);

  localparam logic [ITER_W-1:0] WAIT_LAST  = ITER_W'(NEURON_LAT);
  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);
  localparam logic [DATA_W:0]   TOL        = (DATA_W+1)'(ERR_TOL);

  state_t              r_state;
  state_t              w_next;
  logic [OUT_W-1:0]    r_target;
  logic                r_train;
  logic [ITER_W-1:0]   r_wait_cnt;
  logic [DATA_W-1:0]   w_err;
  logic [DATA_W:0]     w_err_ext;
  logic [DATA_W:0]     w_mag;
  logic                w_within_tol;

  trainer_err_sat #(
    .DATA_W    (DATA_W),
    .OUT_W     (OUT_W),
    .ERR_SHIFT (ERR_SHIFT)
  ) u_err_sat (
    .i_target (r_target),
    .i_actual (neuron_out),
    .o_err    (w_err)
  );

  // Magnitude is one bit wider so the most-negative error cannot wrap.
  always_comb begin
    w_err_ext    = {w_err[DATA_W-1], w_err};
    w_mag        = w_err[DATA_W-1] ? -w_err_ext : w_err_ext;
    w_within_tol = (w_mag <= TOL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    learn_en = 1'b0;
    r_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (s_valid && s_ready) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_wait_cnt == WAIT_LAST) w_next = ST_EVAL;
      end
      ST_EVAL: begin
        if (!r_train || w_within_tol) begin
          w_next = ST_DONE;
`ifdef TRAINER_CONVERGE_EN
        end else if (r_iters == ITER_LIMIT) begin
          w_next = ST_DONE;
`endif
        end else begin
          w_next = ST_LEARN;
        end
      end
      ST_LEARN: begin
        learn_en = 1'b1;
`ifdef TRAINER_CONVERGE_EN
        w_next   = ST_WAIT;
`else
        w_next   = ST_DONE;
`endif
      end
      ST_DONE: begin
        r_valid = 1'b1;
        if (r_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // s_ready is registered so it stays low while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready        <= 1'b0;
      neuron_in      <= '0;
      r_target       <= '0;
      r_train        <= 1'b0;
      r_wait_cnt     <= '0;
      feedback_error <= '0;
      r_error        <= '0;
      r_iters        <= '0;
      r_converged    <= 1'b0;
    end else begin
      s_ready <= (w_next == ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (s_valid && s_ready) begin
            neuron_in  <= s_stim;
            r_target   <= s_target;
            r_train    <= s_train;
            r_iters    <= '0;
            r_wait_cnt <= '0;
          end
        end
        ST_WAIT: r_wait_cnt <= r_wait_cnt + ITER_W'(1);
        ST_EVAL: begin
          feedback_error <= w_err;
          r_error        <= w_err;
          r_converged    <= w_within_tol;
        end
        ST_LEARN: begin
          r_wait_cnt <= '0;
          if (r_iters != ITER_LIMIT) r_iters <= r_iters + ITER_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/hebbian_trainer.md
# hebbian_trainer

- Supervisory block driving one plastic neuron in a closed training loop.
- Accepts (stimulus, target) samples over valid/ready and drives the neuron's input.
- Waits out the neuron's inference latency, then computes a scaled, saturated signed error and issues one-cycle learning pulses with that error.
- Returns a result record to the upstream controller.

## Interface
- `DATA_W`, 16: neuron input and feedback error width.
- `OUT_W`, 32: neuron output and target width.
- `NEURON_LAT`, 1: neuron input-to-output register latency, in cycles.
- `ERR_SHIFT`, 4: arithmetic right shift applied to the raw error.
- `ERR_TOL`, 0: convergence tolerance on the magnitude of the scaled error.
- `MAX_ITER`, 255: learning-pulse limit per sample; legal range 1..255.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: a sample is offered.
- `s_ready` out 1: high only in IDLE.
- `s_stim` in DATA_W: signed stimulus.
- `s_target` in OUT_W: signed desired neuron output.
- `s_train` in 1: 1 = learn on this sample; 0 = inference only.
- `neuron_in` out DATA_W: drives the neuron input.
- `neuron_out` in OUT_W: neuron output.
- `feedback_error` out DATA_W: signed error to the neuron.
- `learn_en` out 1: neuron plasticity enable.
- `r_valid` out 1: result available.
- `r_ready` in 1: result consumed.
- `r_error` out DATA_W: final scaled error.
- `r_iters` out 8: learning pulses issued for this sample.
- `r_converged` out 1: final error magnitude ≤ ERR_TOL.

## Operation
- FSM states: IDLE, WAIT, EVAL, LEARN, DONE.
- IDLE: `s_ready`=1. On `s_valid`&&`s_ready`, register stim, target and train; set `neuron_in`=stim; clear the iteration counter; go to WAIT.
- WAIT: count NEURON_LAT+1 cycles, then go to EVAL. The extra cycle covers the weight update following a LEARN.
- EVAL: capture `neuron_out` and compute diff = target − neuron_out in OUT_W+1 bits signed.
  - Shift diff right arithmetically by ERR_SHIFT.
  - Saturate the result to the signed DATA_W range [−32768, 32767].
  - Register it into `feedback_error`.
- EVAL exit:
  - If train=0, or the error magnitude is ≤ ERR_TOL, go to DONE.
  - Otherwise go to LEARN.
- LEARN: `learn_en`=1 for exactly one cycle; increment the iteration counter. The next state depends on the configuration.
- DONE: `r_valid`=1 with the fields stable. On `r_ready`, go to IDLE.
- `feedback_error` holds its value between EVALs. `learn_en` is 1 only in LEARN.
- `neuron_in` holds the stimulus through DONE and keeps its value in IDLE until the next accept.
- Boundary cases:
  - A most-negative error saturates to −32768; its magnitude is computed in DATA_W+1 bits, so it never wraps.
  - The iteration counter never exceeds MAX_ITER.
  - `r_ready` asserted early, before `r_valid`, has no effect.

## Timing
- Reset values: `s_ready`=0 during reset and 1 after the first clock; `neuron_in`=0; `feedback_error`=0; `learn_en`=0; `r_valid`=0; `r_error`=0; `r_iters`=0; `r_converged`=0; state IDLE.
- Accept at edge k puts `neuron_in` valid at k. EVAL occupies cycle k+NEURON_LAT+2.
- Inference-only latency: accept to `r_valid` is NEURON_LAT+3 cycles.
- Each learning iteration adds NEURON_LAT+3 cycles: LEARN, then WAIT, then EVAL.
- A reset assertion mid-sample aborts immediately to reset values. No result is produced.

## Configuration
- `TRAINER_CONVERGE_EN` defined: LEARN returns to WAIT.
  - The loop repeats until the error magnitude is ≤ ERR_TOL, giving `r_converged`=1.
  - It also ends when the counter reaches MAX_ITER; EVAL then goes to DONE with `r_converged` reflecting the tolerance test.
- Undefined: at most one LEARN per sample, and LEARN goes to DONE.
  - `r_error` is the pre-learn error.
  - `r_iters` is 0 or 1.

## Structure
- `trainer_pkg`: FSM state enum, DATA_W/OUT_W defaults, the iteration-counter width (8), and the saturation limit constants.
- Sub-module `trainer_err_sat`: combinational subtract, shift and saturate, instantiated once in EVAL.

## Test plan
All scenarios use a neuron model with initial weight 1000, +10 per learn on positive error, and NEURON_LAT=1.
- stim=2, target=2000, train=1 -> error 0, `learn_en` never pulses, `r_converged`=1, `r_iters`=0, `r_valid` 4 cycles after accept.
- With the macro, stim=2, target=2100 -> errors 6, 5, 3, 2, 1, 0 in successive EVALs, `r_iters`=5, `r_converged`=1.
- Without the macro, same stimulus -> exactly one `learn_en` pulse with `feedback_error`=6, `r_error`=6, `r_iters`=1, `r_converged`=0.
- target=0x7FFFFFFF with `neuron_out` forced to 0x80000000 -> `feedback_error`=32767; reversed -> −32768.
- train=0, target=2100 -> `learn_en` never asserts, `r_error`=6, `r_iters`=0.
- Assert `rst_n` low during WAIT -> all outputs return to reset values; the next sample runs normally.
